// File: rtl/ddr_sched_pkg.sv
// Shared state type, widths and default geometry for the
// frame read/write DDR burst scheduler.
package ddr_sched_pkg;

    localparam int ADDR_W = 28;
    localparam int LEN_W  = 11;
    localparam int CNT_W  = 10;

    localparam int unsigned DEF_BURST_WORDS   = 128;
    localparam int unsigned DEF_FRAME_WORDS   = 786432;
    localparam int unsigned DEF_RD_FIFO_DEPTH = 512;

    localparam logic [ADDR_W-1:0] DEF_BANK_STRIDE =
        28'h0100000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT,
        S_RD_REQ,
        S_RD_WAIT
    } sched_state_e;

    // 16-bit words to 128-bit FIFO entries
    function automatic int unsigned fifo_entries(
        input int unsigned words
    );
        return words / 8;
    endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// One direction's burst address: offset counter with frame
// wrap, bank register and a pending frame-start.
module frame_addr_gen
    import ddr_sched_pkg::*;
#(
    parameter int unsigned       BURST_WORDS = DEF_BURST_WORDS,
    parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS,
    parameter logic [ADDR_W-1:0] BANK_STRIDE = DEF_BANK_STRIDE,
    parameter logic              RESET_BANK  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              frame_start,
    input  logic              apply_en,
    input  logic              toggle_on_wrap,
    input  logic              load_bank,
    input  logic              start_bank,
    output logic              bank,
    output logic              wrap,
    output logic [ADDR_W-1:0] adrs
);

    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BURST_WORDS);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(FRAME_WORDS);

    logic [ADDR_W-1:0] offset_q;
    logic [ADDR_W-1:0] offset_inc;
    logic              pend_q;
    logic              apply;

    assign offset_inc = offset_q + STEP;
    assign wrap       = advance && (offset_inc >= LIMIT);
    assign apply      = apply_en && (pend_q || frame_start);
    assign adrs       = (bank ? BANK_STRIDE : '0) + offset_q;

    // advance and apply never coincide: one is WAIT-only,
    // the other IDLE-only, so a wrap always lands first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_q <= '0;
            bank     <= RESET_BANK;
            pend_q   <= 1'b0;
        end else begin
            if (advance) begin
                offset_q <= wrap ? '0 : offset_inc;
                if (wrap && toggle_on_wrap) begin
                    bank <= ~bank;
                end
            end else if (apply) begin
                offset_q <= '0;
                if (load_bank) begin
                    bank <= start_bank;
                end
            end
            pend_q <= apply ? 1'b0 : (pend_q || frame_start);
        end
    end

endmodule

// File: rtl/frame_rw_scheduler.sv
// Arbitrates DDR write and read bursts for a double-buffered
// frame store; write fills one bank while read replays the other.
module frame_rw_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int unsigned       BURST_WORDS   = DEF_BURST_WORDS,
    parameter int unsigned       FRAME_WORDS   = DEF_FRAME_WORDS,
    parameter logic [ADDR_W-1:0] BANK_STRIDE   = DEF_BANK_STRIDE,
    parameter int unsigned       RD_FIFO_DEPTH = DEF_RD_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ddr_init_done,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic [CNT_W-1:0]  wr_fifo_cnt,
    input  logic [CNT_W-1:0]  rd_fifo_cnt,
    input  logic              wr_ready,
    input  logic              wr_done,
    input  logic              rd_ready,
    input  logic              rd_done,
    output logic              wr_start,
    output logic              rd_start,
    output logic [ADDR_W-1:0] wr_adrs,
    output logic [ADDR_W-1:0] rd_adrs,
    output logic [LEN_W-1:0]  wr_len,
    output logic [LEN_W-1:0]  rd_len,
    output logic              busy
);

    localparam int unsigned ENTRIES = fifo_entries(BURST_WORDS);
    localparam int unsigned RD_ROOM = RD_FIFO_DEPTH - ENTRIES;

    sched_state_e state_q;
    sched_state_e state_d;

    logic last_rd_q;
    logic frame_valid_q;
    logic wr_cond;
    logic rd_cond;
    logic idle;
    logic wr_adv;
    logic rd_adv;
    logic wr_bank;
    logic wr_wrap;
    logic rd_bank;
    logic rd_wrap;
    logic unused_rd_status;

    assign idle    = (state_q == S_IDLE);
    assign wr_adv  = (state_q == S_WR_WAIT) && wr_done;
    assign rd_adv  = (state_q == S_RD_WAIT) && rd_done;
    assign wr_len  = LEN_W'(BURST_WORDS);
    assign rd_len  = LEN_W'(BURST_WORDS);

    assign wr_cond = ddr_init_done
                  && (32'(wr_fifo_cnt) >= ENTRIES);
    assign rd_cond = ddr_init_done && frame_valid_q
                  && (32'(rd_fifo_cnt) <= RD_ROOM);

    assign unused_rd_status = ^{rd_bank, rd_wrap};

    frame_addr_gen #(
        .BURST_WORDS (BURST_WORDS),
        .FRAME_WORDS (FRAME_WORDS),
        .BANK_STRIDE (BANK_STRIDE),
        .RESET_BANK  (1'b0)
    ) u_wr_gen (
        .clk            (clk),
        .rst            (rst),
        .advance        (wr_adv),
        .frame_start    (wr_frame_start),
        .apply_en       (idle),
        .toggle_on_wrap (1'b1),
        .load_bank      (1'b0),
        .start_bank     (1'b0),
        .bank           (wr_bank),
        .wrap           (wr_wrap),
        .adrs           (wr_adrs)
    );

    // a read frame-start locks onto the last completed frame
    frame_addr_gen #(
        .BURST_WORDS (BURST_WORDS),
        .FRAME_WORDS (FRAME_WORDS),
        .BANK_STRIDE (BANK_STRIDE),
        .RESET_BANK  (1'b1)
    ) u_rd_gen (
        .clk            (clk),
        .rst            (rst),
        .advance        (rd_adv),
        .frame_start    (rd_frame_start),
        .apply_en       (idle),
        .toggle_on_wrap (1'b0),
        .load_bank      (1'b1),
        .start_bank     (~wr_bank),
        .bank           (rd_bank),
        .wrap           (rd_wrap),
        .adrs           (rd_adrs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_rd_q     <= 1'b1;
            frame_valid_q <= 1'b0;
        end else begin
            if (wr_adv) begin
                last_rd_q <= 1'b0;
            end else if (rd_adv) begin
                last_rd_q <= 1'b1;
            end
            if (wr_wrap) begin
                frame_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_cond && (!rd_cond || last_rd_q)) begin
                    state_d = S_WR_REQ;
                end else if (rd_cond) begin
                    state_d = S_RD_REQ;
                end
            end
            S_WR_REQ:  if (wr_ready) state_d = S_WR_WAIT;
            S_WR_WAIT: if (wr_done)  state_d = S_IDLE;
            S_RD_REQ:  if (rd_ready) state_d = S_RD_WAIT;
            S_RD_WAIT: if (rd_done)  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_start = 1'b0;
        rd_start = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            S_IDLE:   busy     = 1'b0;
            S_WR_REQ: wr_start = wr_ready;
            S_RD_REQ: rd_start = rd_ready;
            default:  busy     = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_frame_rw_scheduler.sv
// Bench for frame_rw_scheduler: directed table, corner
// sequences and randomized traffic against a reference model.
module tb_frame_rw_scheduler;

    localparam int BW     = 128;
    localparam int FW     = 512;
    localparam int STRIDE = 'h100000;
    localparam int DEPTH  = 512;

    logic        clk;
    logic        rst;
    logic        init;
    logic        wfs;
    logic        rfs;
    logic [9:0]  wcnt;
    logic [9:0]  rcnt;
    logic        wrdy;
    logic        wdone;
    logic        rrdy;
    logic        rdone;
    logic        ws;
    logic        rs;
    logic [27:0] wa;
    logic [27:0] ra;
    logic [10:0] wl;
    logic [10:0] rl;
    logic        busy;

    int n_vec;
    int n_err;

    frame_rw_scheduler #(
        .BURST_WORDS   (BW),
        .FRAME_WORDS   (FW),
        .BANK_STRIDE   (28'h0100000),
        .RD_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ddr_init_done  (init),
        .wr_frame_start (wfs),
        .rd_frame_start (rfs),
        .wr_fifo_cnt    (wcnt),
        .rd_fifo_cnt    (rcnt),
        .wr_ready       (wrdy),
        .wr_done        (wdone),
        .rd_ready       (rrdy),
        .rd_done        (rdone),
        .wr_start       (ws),
        .rd_start       (rs),
        .wr_adrs        (wa),
        .rd_adrs        (ra),
        .wr_len         (wl),
        .rd_len         (rl),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [95:0] act,
                       input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    function automatic logic [95:0] dut_bundle();
        return 96'({ws, rs, busy, wa, ra, wl, rl});
    endfunction

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 write granted, 2 write in flight,
    //        3 read granted, 4 read in flight
    int m_ph;
    int m_wo;
    int m_ro;
    bit m_wb;
    bit m_rb;
    bit m_fv;
    bit m_wp;
    bit m_rp;
    bit m_rd_last;

    function automatic void m_reset();
        m_ph = 0; m_wo = 0; m_ro = 0;
        m_wb = 0; m_rb = 1; m_fv = 0;
        m_wp = 0; m_rp = 0; m_rd_last = 1;
    endfunction

    function automatic logic [27:0] m_adr(bit b, int off);
        longint a;
        a = (b ? longint'(STRIDE) : 64'sd0) + longint'(off);
        return 28'(a % (64'sd1 << 28));
    endfunction

    function automatic logic [95:0] m_expect();
        logic e_ws;
        logic e_rs;
        logic e_busy;
        e_ws   = (m_ph == 1) && wrdy;
        e_rs   = (m_ph == 3) && rrdy;
        e_busy = (m_ph != 0);
        return 96'({e_ws, e_rs, e_busy,
                    m_adr(m_wb, m_wo), m_adr(m_rb, m_ro),
                    11'(BW), 11'(BW)});
    endfunction

    function automatic void m_update();
        bit wq;
        bit rq;
        wq = init && (int'(wcnt) >= BW / 8);
        rq = init && m_fv && (int'(rcnt) <= DEPTH - BW / 8);
        if (m_ph == 0) begin
            if (m_wp || wfs) begin
                m_wo = 0; m_wp = 0;
            end
            if (m_rp || rfs) begin
                m_ro = 0; m_rb = !m_wb; m_rp = 0;
            end
            if (wq && (!rq || m_rd_last)) m_ph = 1;
            else if (rq) m_ph = 3;
        end else begin
            if (wfs) m_wp = 1;
            if (rfs) m_rp = 1;
            case (m_ph)
                1: if (wrdy) m_ph = 2;
                2: if (wdone) begin
                    m_wo += BW;
                    if (m_wo >= FW) begin
                        m_wo = 0; m_wb = !m_wb; m_fv = 1;
                    end
                    m_rd_last = 0;
                    m_ph = 0;
                end
                3: if (rrdy) m_ph = 4;
                4: if (rdone) begin
                    m_ro += BW;
                    if (m_ro >= FW) m_ro = 0;
                    m_rd_last = 1;
                    m_ph = 0;
                end
                default: m_ph = 0;
            endcase
        end
    endfunction

    // inputs are set at negedge+1; compare, advance one clock
    task automatic step();
        #1;
        if (rst) m_reset();
        chk("model", dut_bundle(), m_expect());
        if (!rst) m_update();
        @(negedge clk);
        wfs = 0; rfs = 0; wdone = 0; rdone = 0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic burst_w();
        step();
        step();
        wdone = 1;
        step();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        init;
        logic        wd;
        logic        rd;
        logic        ws;
        logic        rs;
        logic        busy;
        logic [27:0] wa;
        logic [27:0] ra;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic i, input logic wd,
                       input logic rd, input logic e_ws,
                       input logic e_rs, input logic e_b,
                       input logic [27:0] e_wa,
                       input logic [27:0] e_ra);
        vec_t v;
        v.init = i; v.wd = wd; v.rd = rd;
        v.ws = e_ws; v.rs = e_rs; v.busy = e_b;
        v.wa = e_wa; v.ra = e_ra;
        tbl.push_back(v);
    endtask

    initial begin
        clk = 0; rst = 1; init = 0;
        wfs = 0; rfs = 0; wdone = 0; rdone = 0;
        wcnt = 10'd20; rcnt = 10'd0;
        wrdy = 1; rrdy = 1;
        n_vec = 0; n_err = 0;
        m_reset();

        add(0,0,0, 0,0,0, 28'h0,      28'h100000);
        add(0,0,0, 0,0,0, 28'h0,      28'h100000);
        add(1,0,0, 0,0,0, 28'h0,      28'h100000);
        add(1,0,0, 1,0,1, 28'h0,      28'h100000);
        add(1,0,0, 0,0,1, 28'h0,      28'h100000);
        add(1,1,0, 0,0,1, 28'h0,      28'h100000);
        add(1,0,0, 0,0,0, 28'h80,     28'h100000);
        add(1,0,0, 1,0,1, 28'h80,     28'h100000);
        add(1,1,0, 0,0,1, 28'h80,     28'h100000);
        add(1,0,0, 0,0,0, 28'h100,    28'h100000);
        add(1,0,0, 1,0,1, 28'h100,    28'h100000);
        add(1,1,0, 0,0,1, 28'h100,    28'h100000);
        add(1,0,0, 0,0,0, 28'h180,    28'h100000);
        add(1,0,0, 1,0,1, 28'h180,    28'h100000);
        add(1,1,0, 0,0,1, 28'h180,    28'h100000);
        add(1,0,0, 0,0,0, 28'h100000, 28'h100000);
        add(1,0,0, 0,1,1, 28'h100000, 28'h100000);
        add(1,0,1, 0,0,1, 28'h100000, 28'h100000);
        add(1,0,0, 0,0,0, 28'h100000, 28'h100080);
        add(1,0,0, 1,0,1, 28'h100000, 28'h100080);
        add(1,0,1, 0,0,1, 28'h100000, 28'h100080);
        add(1,1,0, 0,0,1, 28'h100000, 28'h100080);
        add(1,0,0, 0,0,0, 28'h100080, 28'h100080);
        add(1,0,0, 0,1,1, 28'h100080, 28'h100080);

        @(negedge clk);
        #1;
        chk("reset_state", dut_bundle(),
            96'({1'b0, 1'b0, 1'b0, 28'h0, 28'h100000,
                 11'd128, 11'd128}));
        rst = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            init  = tbl[i].init;
            wdone = tbl[i].wd;
            rdone = tbl[i].rd;
            #1;
            chk($sformatf("vec%0d", i),
                96'({ws, rs, busy, wa, ra}),
                96'({tbl[i].ws, tbl[i].rs, tbl[i].busy,
                     tbl[i].wa, tbl[i].ra}));
            @(negedge clk);
            #1;
        end
        wdone = 0; rdone = 0;

        // write frame-start mid-frame, then coincident with wrap
        do_reset();
        init = 1; wcnt = 10'd20; rcnt = 10'd1023;
        wrdy = 1; rrdy = 1;
        burst_w();
        burst_w();
        step();
        step();
        wfs = 1;
        step();
        wdone = 1;
        step();
        step();
        chk("fs_restart", 96'({ws, wa}), 96'({1'b1, 28'h0}));
        step();
        wdone = 1;
        step();
        burst_w();
        burst_w();
        step();
        step();
        wfs = 1; wdone = 1;
        step();
        step();
        chk("fs_at_wrap", 96'({ws, wa}),
            96'({1'b1, 28'h100000}));
        step();
        wdone = 1;
        step();

        // reset during a read burst, then read frame-start
        do_reset();
        init = 1; wcnt = 10'd20; rcnt = 10'd1023;
        repeat (4) burst_w();
        wcnt = 10'd0; rcnt = 10'd0;
        step();
        chk("rd_first", 96'({rs, ra}), 96'({1'b1, 28'h100000}));
        step();
        step();
        rst = 1;
        #1;
        chk("rst_async", 96'({busy, rs, ws, wa, ra}),
            96'({1'b0, 1'b0, 1'b0, 28'h0, 28'h100000}));
        step();
        rst = 0;
        repeat (10) begin
            step();
            chk("no_rd_after_rst", 96'(rs), 96'(0));
        end
        wcnt = 10'd20; rcnt = 10'd1023;
        repeat (4) burst_w();
        wcnt = 10'd0; rcnt = 10'd0; rfs = 1;
        step();
        chk("rd_fs_bank", 96'({rs, ra}), 96'({1'b1, 28'h0}));
        step();
        rdone = 1;
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 499) == 0);
            init  = ($urandom_range(0, 9) != 0);
            wcnt  = 10'($urandom_range(12, 20));
            rcnt  = 10'($urandom_range(490, 500));
            wrdy  = 1'($urandom_range(0, 1));
            rrdy  = 1'($urandom_range(0, 1));
            wdone = ($urandom_range(0, 3) == 0);
            rdone = ($urandom_range(0, 3) == 0);
            wfs   = ($urandom_range(0, 39) == 0);
            rfs   = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
